regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with N combinational read ports, one write port with same-cycle write-to-read bypass, and an integrated busy-bit scoreboard for pipeline hazard detection. After reset, a hardware sweep clears the storage, so no external initialisation is needed. Sits in the decode/writeback boundary of the RV32I core. Issue marks a destination register busy; writeback clears it. Hazard status is reported per read port.

## Interface
Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of registers; AW = clog2(NREGS).
- NRP, 2, number of read ports.
- ZERO_REG, 1, 1 = register 0 is hardwired zero and never busy.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- ready  out  1  high once the clear sweep is complete.
- re  in  NRP  per-port read enable.
- ra  in  NRP*AW  per-port read address; port i occupies bits [i*AW +: AW].
- rdata  out  NRP*XLEN  per-port read data.
- rbusy  out  NRP  per-port flag: source has a pending producer that is not bypassed.
- stall  out  1  OR of rbusy.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wdata  in  XLEN  writeback data.
- iss_valid  in  1  instruction issue; marks iss_rd busy.
- iss_rd  in  AW  destination register of the issuing instruction.

## Operation
- FSM with two states, CLEAR and RUN.
  - reset==0 at a clock edge: state<=CLEAR, ptr<=0, busy<=0.
  - In CLEAR with reset==1: mem[ptr]<=0 and ptr<=ptr+1 each cycle. The cycle that writes ptr==NREGS-1 moves the FSM to RUN.
  - RUN persists until reset.
- ready = (state==RUN). Reset values: ready=0, stall=0, rbusy=0, rdata=0.
- While in CLEAR:
  - we and iss_valid are ignored.
  - rdata=0, rbusy=0.
- Read, port i (combinational), first match wins:
  - !ready, !re[i], ra[i]>=NREGS, or (ZERO_REG && ra[i]==0): rdata=0.
  - we && wa==ra[i] && the write is legal: rdata=wdata (bypass).
  - Otherwise: rdata=mem[ra[i]].
- rbusy[i] = ready & re[i] & busy[ra[i]] & !(we & wa==ra[i]). Same-cycle writeback resolves the hazard.
- A write is legal when ready, we, wa<NREGS, and !(ZERO_REG && wa==0). A legal write updates mem[wa] at the edge.
- Busy update at the edge, in RUN only:
  - A legal write clears busy[wa].
  - Legal iss_valid sets busy[iss_rd], using the same rules on iss_rd.
  - Same register written and issued in the same cycle: set wins (new producer).
- Writing a non-busy register is allowed; data updates and busy stays 0.
- Issuing to an already-busy register leaves it busy (WAW is tracked by a single bit).

## Timing
- Read: zero latency, combinational from ra/re/we/wa/wdata.
- Write: array updated at the edge and visible from the array the next cycle; visible the same cycle via bypass.
- Busy set: visible on rbusy the cycle after iss_valid.
- Busy clear: rbusy drops the same cycle we is asserted (bypass), and the bit itself clears at the edge.
- ready rises exactly NREGS cycles after the first edge with reset==1.
- Reset asserted mid-operation or mid-sweep:
  - The sweep restarts from ptr=0 after release.
  - All busy bits are cleared.
  - Contents are not preserved.

## Structure
- Package regfile_pkg holds:
  - the state enum (CLEAR, RUN);
  - a clog2 function for deriving AW.
- Sub-module regfile_scoreboard holds:
  - the NREGS busy vector and its set/clear priority logic;
  - NRP lookup outputs.
- The storage array, sweep FSM and bypass mux stay in regfile_sb.

## Test plan
- Reset sweep:
  - Hold reset=0 for 3 cycles, release.
  - ready=0 for exactly 32 cycles, then 1.
  - Reading any address afterwards returns 0.
- Write then read:
  - we=1, wa=5, wdata=0xDEADBEEF with re[0]=1, ra[0]=5.
  - rdata0=0xDEADBEEF in the same cycle (bypass), and again the next cycle from the array.
- x0 protection:
  - Write wa=0, wdata=0x1234; iss_valid with iss_rd=0.
  - Reading ra=0 returns 0 and rbusy=0.
- Scoreboard:
  - iss_valid, iss_rd=7; the next cycle read ra[1]=7.
  - rbusy[1]=1 and stall=1 until the cycle we=1, wa=7, wdata=0x55, which gives rdata1=0x55, rbusy[1]=0, stall=0.
- Simultaneous issue and write:
  - iss_rd=9 and wa=9 in the same cycle.
  - The next cycle busy[9]=1 and rbusy=1 on read of 9.
- Mid-run reset:
  - After writing reg 3 = 0xA5 and marking reg 4 busy, pulse reset=0 for 1 cycle.
  - ready drops, then returns after 32 cycles; reg 3 reads 0 and reg 4 is not busy.
- During the sweep, we=1, wa=2 is ignored: reg 2 still reads 0 after ready.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file slice.
package regfile_pkg;

   // Sweep FSM: CLEAR zeroes the storage after reset, RUN is normal operation.
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Address width for n entries; at least one bit so ports never collapse to zero width.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: read ports, writeback, issue, status.
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NRP   = 2
);
   localparam int unsigned AW = clog2(NREGS);

   logic                  ready;
   logic [NRP-1:0]        re;
   logic [NRP*AW-1:0]     ra;
   logic [NRP*XLEN-1:0]   rdata;
   logic [NRP-1:0]        rbusy;
   logic                  stall;
   logic                  we;
   logic [AW-1:0]         wa;
   logic [XLEN-1:0]       wdata;
   logic                  iss_valid;
   logic [AW-1:0]         iss_rd;

   modport master (
      input  ready, rdata, rbusy, stall,
      output re, ra, we, wa, wdata, iss_valid, iss_rd
   );

   modport slave (
      output ready, rdata, rbusy, stall,
      input  re, ra, we, wa, wdata, iss_valid, iss_rd
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register plus per-port hazard lookup.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREGS = 32,
   parameter int unsigned NRP   = 2,
   parameter int unsigned AW    = clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              wr_clr,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic              iss_set,
   input  logic [AW-1:0]     iss_rd,
   input  logic [NRP-1:0]    re,
   input  logic [NRP*AW-1:0] ra,
   output logic [NRP-1:0]    rbusy_c
);

   logic [NREGS-1:0] busy;

   // Writeback clears, issue sets; issue is applied last so a new producer wins.
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy <= '0;
      end else if (run) begin
         if (wr_clr) begin
            busy[wa] <= 1'b0;
         end
         if (iss_set) begin
            busy[iss_rd] <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NRP; g++) begin : g_look
      logic [AW-1:0] a;
      logic          hit;

      assign a = ra[g*AW +: AW];

      // Busy source that is not being written back this very cycle.
      always_comb begin
         hit = 1'b0;
         if (32'(a) < NREGS) begin
            hit = busy[a];
         end
      end

      assign rbusy_c[g] = run & re[g] & hit & ~(we & (wa == a));
   end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with N read ports, bypassed writeback and busy-bit scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned NRP      = 2,
   parameter bit          ZERO_REG = 1'b1
) (
   input logic         clk,
   input logic         reset,
   regfile_sb_if.slave bus
);

   localparam int unsigned AW = clog2(NREGS);

   state_t              state;
   state_t              state_nxt;
   logic [AW-1:0]       ptr;
   logic                ready_c;
   logic                sweep_c;
   logic                wr_legal_c;
   logic                iss_legal_c;
   logic [XLEN-1:0]     mem [NREGS];
   logic [NRP*XLEN-1:0] rdata_c;
   logic [NRP-1:0]      rbusy_c;

   // Address names a real, writable register (x0 excluded when hardwired).
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (32'(a) < NREGS) && !(ZERO_REG && (a == '0));
   endfunction

   // Sweep FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // Leave CLEAR on the cycle that zeroes the last entry.
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR: if (ptr == AW'(NREGS - 1)) state_nxt = RUN;
         RUN:   state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   // FSM outputs: sweep write strobe in CLEAR, ready in RUN.
   always_comb begin
      ready_c = 1'b0;
      sweep_c = 1'b0;
      case (state)
         CLEAR:   sweep_c = 1'b1;
         RUN:     ready_c = 1'b1;
         default: sweep_c = 1'b1;
      endcase
   end

   // Sweep pointer restarts from zero on every reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr <= '0;
      end else if (sweep_c) begin
         ptr <= ptr + AW'(1);
      end
   end

   assign wr_legal_c  = ready_c & bus.we & addr_ok(bus.wa);
   assign iss_legal_c = ready_c & bus.iss_valid & addr_ok(bus.iss_rd);

   // Storage: zeroed by the sweep, then written by legal writebacks.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (sweep_c) begin
            mem[ptr] <= '0;
         end else if (wr_legal_c) begin
            mem[bus.wa] <= bus.wdata;
         end
      end
   end

   for (genvar g = 0; g < NRP; g++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;

      assign a = bus.ra[g*AW +: AW];

      // Read mux: gated zero, then same-cycle writeback bypass, then array.
      always_comb begin
         d = '0;
         if (!ready_c || !bus.re[g] || !addr_ok(a)) begin
            d = '0;
         end else if (wr_legal_c && (bus.wa == a)) begin
            d = bus.wdata;
         end else begin
            d = mem[a];
         end
      end

      assign rdata_c[g*XLEN +: XLEN] = d;
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NRP   (NRP),
      .AW    (AW)
   ) u_sb (
      .clk     (clk),
      .reset   (reset),
      .run     (ready_c),
      .wr_clr  (wr_legal_c),
      .we      (bus.we),
      .wa      (bus.wa),
      .iss_set (iss_legal_c),
      .iss_rd  (bus.iss_rd),
      .re      (bus.re),
      .ra      (bus.ra),
      .rbusy_c (rbusy_c)
   );

   assign bus.ready = ready_c;
   assign bus.rdata = rdata_c;
   assign bus.rbusy = rbusy_c;
   assign bus.stall = |rbusy_c;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table plus reset/sweep sequences.
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NRP   = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) bus ();

   regfile_sb #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NRP      (NRP),
      .ZERO_REG (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  re;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wdata;
      logic        iv;
      logic [4:0]  ird;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic [1:0]  e_busy;
   } vec_t;

   typedef struct {
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  busy;
      logic        stall;
      logic        ready;
   } exp_t;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t expq[$];
   vec_t tbl[$];

   function automatic vec_t mk(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic we, input logic [4:0] wa, input logic [31:0] wdata,
                               input logic iv, input logic [4:0] ird,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
      vec_t v;
      v.re = re; v.ra0 = ra0; v.ra1 = ra1;
      v.we = we; v.wa = wa; v.wdata = wdata;
      v.iv = iv; v.ird = ird;
      v.e_rd0 = e0; v.e_rd1 = e1; v.e_busy = eb;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Apply one vector at the falling edge and queue what the outputs must show.
   task automatic drive(input vec_t v);
      exp_t e;
      @(negedge clk);
      bus.re        = v.re;
      bus.ra        = {v.ra1, v.ra0};
      bus.we        = v.we;
      bus.wa        = v.wa;
      bus.wdata     = v.wdata;
      bus.iss_valid = v.iv;
      bus.iss_rd    = v.ird;
      e.rd0   = v.e_rd0;
      e.rd1   = v.e_rd1;
      e.busy  = v.e_busy;
      e.stall = |v.e_busy;
      e.ready = 1'b1;
      expq.push_back(e);
   endtask

   // Outputs are combinational: compare once they settle, before the next edge.
   task automatic sample(input string tag);
      exp_t e;
      #1;
      if (expq.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_queue: got empty, expected one entry", tag);
      end else begin
         e = expq.pop_front();
         chk({tag, "_rdata0"}, bus.rdata[31:0], e.rd0);
         chk({tag, "_rdata1"}, bus.rdata[63:32], e.rd1);
         chk({tag, "_rbusy"}, 32'(bus.rbusy), 32'(e.busy));
         chk({tag, "_stall"}, 32'(bus.stall), 32'(e.stall));
         chk({tag, "_ready"}, 32'(bus.ready), 32'(e.ready));
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      drive(v);
      sample(tag);
   endtask

   // Count edges from release until ready; writeback/issue are dropped as soon as ready rises.
   task automatic wait_ready(input string tag);
      int cnt;
      bit done;
      cnt  = 0;
      done = 1'b0;
      while (!done && cnt < 100) begin
         @(posedge clk);
         cnt++;
         #1;
         if (bus.ready === 1'b1) done = 1'b1;
      end
      bus.we        = 1'b0;
      bus.iss_valid = 1'b0;
      chk({tag, "_ready_edges"}, 32'(cnt), 32'(NREGS));
      chk({tag, "_ready_high"}, 32'(bus.ready), 32'd1);
   endtask

   initial begin
      reset         = 1'b0;
      bus.re        = 2'b11;
      bus.ra        = {5'd1, 5'd0};
      bus.we        = 1'b0;
      bus.wa        = '0;
      bus.wdata     = '0;
      bus.iss_valid = 1'b0;
      bus.iss_rd    = '0;

      // Reset held for three edges.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_rbusy", 32'(bus.rbusy), 32'd0);
      chk("rst_rdata", bus.rdata[31:0] | bus.rdata[63:32], 32'd0);

      // Release with a writeback and issue pending; both must be ignored during the sweep.
      @(negedge clk);
      reset         = 1'b1;
      bus.re        = 2'b11;
      bus.ra        = {5'd6, 5'd2};
      bus.we        = 1'b1;
      bus.wa        = 5'd2;
      bus.wdata     = 32'hFFFF_FFFF;
      bus.iss_valid = 1'b1;
      bus.iss_rd    = 5'd6;
      #1;
      chk("sweep_rdata0", bus.rdata[31:0], 32'd0);
      chk("sweep_rbusy", 32'(bus.rbusy), 32'd0);
      wait_ready("sweep");

      // Every register reads zero after the sweep.
      for (int k = 0; k < 16; k++) begin
         tbl.push_back(mk(2'b11, 5'(2*k), 5'(2*k+1), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00));
      end
      // Write/bypass, x0 protection, scoreboard set/clear, WAW and simultaneous issue+write.
      tbl.push_back(mk(2'b01, 5'd5,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'hDEADBEEF, 32'd0,        2'b00));
      tbl.push_back(mk(2'b11, 5'd5,  5'd5,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00));
      tbl.push_back(mk(2'b10, 5'd5,  5'd5,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        32'hDEADBEEF, 2'b00));
      tbl.push_back(mk(2'b11, 5'd0,  5'd0,  1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  32'd0,        32'd0,        2'b00));
      tbl.push_back(mk(2'b11, 5'd0,  5'd5,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        32'hDEADBEEF, 2'b00));
      tbl.push_back(mk(2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'd0,        1'b1, 5'd7,  32'd0,        32'd0,        2'b00));
      tbl.push_back(mk(2'b10, 5'd7,  5'd7,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        32'd0,        2'b10));
      tbl.push_back(mk(2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        32'd0,        2'b11));
      tbl.push_back(mk(2'b11, 5'd7,  5'd7,  1'b1, 5'd7,  32'h55,       1'b0, 5'd0,  32'h55,       32'h55,       2'b00));
      tbl.push_back(mk(2'b11, 5'd7,  5'd5,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'h55,       32'hDEADBEEF, 2'b00));
      tbl.push_back(mk(2'b01, 5'd9,  5'd9,  1'b1, 5'd9,  32'h99,       1'b1, 5'd9,  32'h99,       32'd0,        2'b00));
      tbl.push_back(mk(2'b11, 5'd9,  5'd9,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'h99,       32'h99,       2'b11));
      tbl.push_back(mk(2'b01, 5'd9,  5'd9,  1'b1, 5'd9,  32'hAA,       1'b0, 5'd0,  32'hAA,       32'd0,        2'b00));
      tbl.push_back(mk(2'b11, 5'd9,  5'd9,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'hAA,       32'hAA,       2'b00));
      tbl.push_back(mk(2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  32'd0,        1'b1, 5'd12, 32'd0,        32'd0,        2'b00));
      tbl.push_back(mk(2'b11, 5'd12, 5'd12, 1'b0, 5'd0,  32'd0,        1'b1, 5'd12, 32'd0,        32'd0,        2'b11));
      tbl.push_back(mk(2'b11, 5'd12, 5'd12, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        32'd0,        2'b11));
      tbl.push_back(mk(2'b11, 5'd12, 5'd12, 1'b1, 5'd12, 32'd3,        1'b0, 5'd0,  32'd3,        32'd3,        2'b00));
      tbl.push_back(mk(2'b11, 5'd12, 5'd12, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd3,        32'd3,        2'b00));
      tbl.push_back(mk(2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  32'd0,        1'b1, 5'd20, 32'd0,        32'd0,        2'b00));
      tbl.push_back(mk(2'b11, 5'd20, 5'd21, 1'b1, 5'd21, 32'd1,        1'b0, 5'd0,  32'd0,        32'd1,        2'b01));
      tbl.push_back(mk(2'b11, 5'd20, 5'd21, 1'b1, 5'd20, 32'd2,        1'b0, 5'd0,  32'd2,        32'd1,        2'b00));
      tbl.push_back(mk(2'b11, 5'd2,  5'd6,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        32'd0,        2'b00));

      foreach (tbl[i]) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // Mid-run reset: reg 3 written, reg 4 busy, then a one-cycle reset pulse.
      run_vec(mk(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 32'hA5, 1'b1, 5'd4, 32'd0, 32'd0, 2'b00), "mid_setup");
      run_vec(mk(2'b11, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'hA5, 32'd0, 2'b10), "mid_pre");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_ready", 32'(bus.ready), 32'd0);
      chk("mid_rst_rbusy", 32'(bus.rbusy), 32'd0);
      chk("mid_rst_rdata0", bus.rdata[31:0], 32'd0);
      @(negedge clk);
      reset = 1'b1;
      wait_ready("mid");
      run_vec(mk(2'b11, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00), "mid_post");
      run_vec(mk(2'b11, 5'd5, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00), "mid_post2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
